lcd_text_ctrl: RTL

Upstream content stage for the character-LCD driver. It runs the LCD power-up command sequence once after reset. It then turns 4-bit keypad codes into a stream of 9-bit LCD words ({rs, byte}) and tracks the cursor on a two-line display, inserting DDRAM address commands at line wrap. Its output port connects directly to the LCD driver's data/valid/ready inputs.

---
 rtl/lcd_text_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lcd_text_ctrl.sv
// Character-LCD content stage: runs the power-up command sequence, then turns keypad
// codes into {rs, byte} words while tracking a two-line cursor with automatic wrap.
module lcd_text_ctrl #(
  parameter int          COLS       = 16,
  parameter logic [6:0]  LINE2_BASE = 7'h40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  key_code_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  output logic [8:0]  data_o,
  output logic        data_valid_o,
  input  logic        ready_i,
  output logic        init_done_o
);

  localparam int             CW       = $clog2(COLS + 1);
  localparam logic [CW-1:0]  LAST_COL = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SEND_CHAR,
    S_SEND_WRAP,
    S_SEND_CMD
  } state_t;

  state_t         state_q, state_d;
  logic [8:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic [CW-1:0]  col_q, col_d;
  logic           line_q, line_d;
  logic [1:0]     idx_q, idx_d;

  logic [6:0]     other_base;
  logic           xfer;

  function automatic logic [8:0] init_word(input logic [1:0] idx);
    case (idx)
      2'd0:    init_word = 9'h038;
      2'd1:    init_word = 9'h00C;
      2'd2:    init_word = 9'h006;
      default: init_word = 9'h001;
    endcase
  endfunction

  // Base address of the line the cursor is not on; line 1 wraps back to line 0.
  assign other_base = line_q ? 7'h00 : LINE2_BASE;
  assign xfer       = valid_q && ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = done_q;
    col_d   = col_q;
    line_d  = line_q;
    idx_d   = idx_q;

    case (state_q)
      S_INIT: begin
        if (!valid_q) begin
          data_d  = init_word(idx_q);
          valid_d = 1'b1;
        end else if (ready_i) begin
          if (idx_q == 2'd3) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            col_d   = '0;
            line_d  = 1'b0;
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = init_word(idx_q + 2'd1);
          end
        end
      end

      S_IDLE: begin
        if (key_valid_i) begin
          valid_d = 1'b1;
          if (key_code_i < 4'd10) begin
            state_d = S_SEND_CHAR;
            data_d  = {1'b1, 8'h30 + {4'h0, key_code_i}};
          end else if (key_code_i < 4'd14) begin
            state_d = S_SEND_CHAR;
            data_d  = {1'b1, 8'h37 + {4'h0, key_code_i}};
          end else if (key_code_i == 4'd14) begin
            state_d = S_SEND_CMD;
            data_d  = 9'h001;
          end else begin
            state_d = S_SEND_CMD;
            data_d  = {1'b0, 1'b1, other_base};
          end
        end
      end

      S_SEND_CHAR: begin
        if (xfer) begin
          if (col_q == LAST_COL) begin
            state_d = S_SEND_WRAP;
            data_d  = {1'b0, 1'b1, other_base};
          end else begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            col_d   = col_q + 1'b1;
          end
        end
      end

      S_SEND_WRAP: begin
        if (xfer) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          col_d   = '0;
          line_d  = ~line_q;
        end
      end

      S_SEND_CMD: begin
        if (xfer) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          col_d   = '0;
          // The only command word equal to 9'h001 is clear; anything else is a newline.
          line_d  = (data_q == 9'h001) ? 1'b0 : ~line_q;
        end
      end

      default: begin
        state_d = S_INIT;
        valid_d = 1'b0;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
      data_q  <= 9'h000;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      col_q   <= '0;
      line_q  <= 1'b0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      col_q   <= col_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
    end
  end

  assign key_ready_o  = (state_q == S_IDLE);
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign init_done_o  = done_q;

endmodule
